alu_rs: RTL and testbench
=========================

# alu_rs

Reservation station for the integer ALU in the out-of-order core. Buffers issued ALU and branch-compare instructions, captures missing source operands from the common data bus (ALU and LSB result broadcasts), and dispatches at most one operand-complete instruction per cycle to the ALU. Sits between the decoder/issue stage (upstream) and the ALU (downstream); flushed by the ROB on mispredict.

## Interface

Parameters:
- RS_SIZE_WIDTH, 3, log2 of entry count (RS_SIZE = 1 << RS_SIZE_WIDTH = 8)
- ROB_W, `ROB_SIZE_WIDTH, width of ROB tags

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; when low, all state and outputs hold
- rob_clear  in  1  flush; synchronous, same effect as rst
- issue_valid  in  1  issue an instruction this cycle
- issue_rob_id  in  ROB_W  destination ROB tag
- issue_op  in  3  funct3
- issue_instr_type  in  7  opcode (0010011 / 0110011 = arithmetic, else branch compare)
- issue_op_other  in  1  funct7 bit 5 (sub/sra)
- issue_vj, issue_vk  in  32 each  operand values (valid when dep flag low)
- issue_qj_busy, issue_qk_busy  in  1 each  operand still pending
- issue_qj, issue_qk  in  ROB_W each  producer tags of pending operands
- alu_cdb_ready  in  1  ALU broadcast valid
- alu_cdb_rob_id  in  ROB_W; alu_cdb_result  in  32
- lsb_cdb_ready  in  1  LSB broadcast valid
- lsb_cdb_rob_id  in  ROB_W; lsb_cdb_result  in  32
- full  out  1  no free entry (combinational from registered occupancy)
- alu_valid  out  1  dispatch valid (registered)
- alu_rob_id  out  ROB_W; alu_op  out  3; alu_instr_type  out  7; alu_op_other  out  1
- alu_v1, alu_v2  out  32 each  resolved operand values

## Operation

- Per entry: busy, rob_id, op, instr_type, op_other, vj, vk, qj_busy, qj, qk_busy, qk.
- Issue: when issue_valid, write lowest-index non-busy entry; set busy. Issuer guarantees issue_valid is never asserted while full is high; behaviour in that case is undefined for the instruction but must not corrupt other entries (write is dropped).
- Issue-time bypass: if issue_qj_busy and a CDB broadcast in the same cycle matches issue_qj, store the broadcast value and clear qj_busy; same for k. ALU bus has priority if both match (cannot happen legally).
- Wakeup: every busy entry with qj_busy and qj equal to a valid CDB rob_id takes that result and clears qj_busy; same for k. Both CDBs processed in the same cycle.
- Select: candidate = busy && !qj_busy && !qk_busy, evaluated on registered state (pre-wakeup). Lowest-index candidate dispatches: outputs loaded, alu_valid <= 1, entry busy <= 0. No candidate: alu_valid <= 0, other outputs hold.
- Same entry index may be freed by dispatch and not re-allocated in the same cycle (allocation uses registered busy).
- full = all entries busy.
- rst or rob_clear (when rdy or not): all busy <= 0, all q*_busy <= 0, alu_valid <= 0, all alu_* outputs <= 0. rob_clear discards any same-cycle issue and broadcast.
- rdy low (no rst/clear): no issue, wakeup, or dispatch; outputs hold.

## Timing

- Reset values: full = 0, alu_valid = 0, alu_rob_id/op/instr_type/op_other/v1/v2 = 0.
- Issue with both operands ready at edge N -> alu_valid high after edge N+1; ALU result after edge N+2.
- Operand woken by CDB at edge N (or bypassed at issue at edge N) -> earliest dispatch at edge N+1.
- Throughput: one dispatch per cycle; issue and dispatch in same cycle allowed.
- full reflects state after the last edge; issue at the edge that frees an entry while full is high is not permitted.

## Test plan

- Reset/rdy: assert rst with stale entries -> after edge, full=0, alu_valid=0, all outputs 0; drop rdy with a ready entry -> no dispatch until rdy returns.
- Ready issue: issue add rob 3, vj=5, vk=7 -> next cycle alu_valid=1, alu_rob_id=3, alu_v1=5, alu_v2=7, alu_op=000; following cycle alu_valid=0.
- Wakeup: issue rob 4 with qj_busy, qj=2, vk=1; two cycles later lsb_cdb rob 2 result 0x10 -> alu_valid with alu_v1=0x10 one cycle after broadcast; issue with qk=6 while alu_cdb broadcasts rob 6 = 9 -> dispatched with alu_v2=9.
- Ordering/full: fill 8 entries, all blocked on tag 1 -> full=1; broadcast tag 1 -> eight consecutive dispatches in index order 0..7, full drops after first dispatch.
- Flush: 5 busy entries, rob_clear with concurrent issue_valid -> next cycle full=0, alu_valid=0, no later dispatch of flushed or concurrently issued rob_ids.

Source files
------------

// File: rtl/alu_rs.sv
// alu_rs -- reservation station for the integer ALU.
//
// Buffers issued ALU / branch-compare instructions, captures pending source
// operands from the ALU and LSB result broadcasts, and dispatches at most one
// operand-complete instruction per cycle, lowest entry index first.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   rdy                 global enable; when low all state and outputs hold
//   rob_clear           flush (same effect as rst, discards same-cycle issue)
//   issue_*             instruction from the issue stage (one per cycle)
//   alu_cdb_*           ALU result broadcast (tag + value)
//   lsb_cdb_*           LSB result broadcast (tag + value)
//   full                all entries busy (from registered occupancy)
//   alu_valid, alu_*    registered dispatch to the ALU

`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

module alu_rs #(
    parameter int RS_SIZE_WIDTH = 3,
    parameter int ROB_W         = `ROB_SIZE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rob_clear,

    input  logic             issue_valid,
    input  logic [ROB_W-1:0] issue_rob_id,
    input  logic [2:0]       issue_op,
    input  logic [6:0]       issue_instr_type,
    input  logic             issue_op_other,
    input  logic [31:0]      issue_vj,
    input  logic [31:0]      issue_vk,
    input  logic             issue_qj_busy,
    input  logic             issue_qk_busy,
    input  logic [ROB_W-1:0] issue_qj,
    input  logic [ROB_W-1:0] issue_qk,

    input  logic             alu_cdb_ready,
    input  logic [ROB_W-1:0] alu_cdb_rob_id,
    input  logic [31:0]      alu_cdb_result,
    input  logic             lsb_cdb_ready,
    input  logic [ROB_W-1:0] lsb_cdb_rob_id,
    input  logic [31:0]      lsb_cdb_result,

    output logic             full,
    output logic             alu_valid,
    output logic [ROB_W-1:0] alu_rob_id,
    output logic [2:0]       alu_op,
    output logic [6:0]       alu_instr_type,
    output logic             alu_op_other,
    output logic [31:0]      alu_v1,
    output logic [31:0]      alu_v2
);

    localparam int RS_SIZE = 1 << RS_SIZE_WIDTH;

    // Entry storage
    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] qj_busy;
    logic [RS_SIZE-1:0] qk_busy;
    logic [ROB_W-1:0]   rob_id     [RS_SIZE];
    logic [2:0]         op         [RS_SIZE];
    logic [6:0]         instr_type [RS_SIZE];
    logic               op_other   [RS_SIZE];
    logic [31:0]        vj         [RS_SIZE];
    logic [31:0]        vk         [RS_SIZE];
    logic [ROB_W-1:0]   qj         [RS_SIZE];
    logic [ROB_W-1:0]   qk         [RS_SIZE];

    // Allocation / selection (both on registered state)
    logic                     alloc_valid;
    logic [RS_SIZE_WIDTH-1:0] alloc_idx;
    logic                     sel_valid;
    logic [RS_SIZE_WIDTH-1:0] sel_idx;

    // Issue-time operand after same-cycle broadcast bypass
    logic        iss_qj_busy;
    logic        iss_qk_busy;
    logic [31:0] iss_vj;
    logic [31:0] iss_vk;

    assign full = &busy;

    always_comb begin
        alloc_valid = 1'b0;
        alloc_idx   = '0;
        sel_valid   = 1'b0;
        sel_idx     = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (!alloc_valid && !busy[i]) begin
                alloc_valid = 1'b1;
                alloc_idx   = RS_SIZE_WIDTH'(i);
            end
            if (!sel_valid && busy[i] && !qj_busy[i] && !qk_busy[i]) begin
                sel_valid = 1'b1;
                sel_idx   = RS_SIZE_WIDTH'(i);
            end
        end
    end

    // ALU bus checked first so it wins if both buses carry the same tag
    always_comb begin
        iss_qj_busy = issue_qj_busy;
        iss_vj      = issue_vj;
        if (issue_qj_busy) begin
            if (alu_cdb_ready && alu_cdb_rob_id == issue_qj) begin
                iss_qj_busy = 1'b0;
                iss_vj      = alu_cdb_result;
            end else if (lsb_cdb_ready && lsb_cdb_rob_id == issue_qj) begin
                iss_qj_busy = 1'b0;
                iss_vj      = lsb_cdb_result;
            end
        end
        iss_qk_busy = issue_qk_busy;
        iss_vk      = issue_vk;
        if (issue_qk_busy) begin
            if (alu_cdb_ready && alu_cdb_rob_id == issue_qk) begin
                iss_qk_busy = 1'b0;
                iss_vk      = alu_cdb_result;
            end else if (lsb_cdb_ready && lsb_cdb_rob_id == issue_qk) begin
                iss_qk_busy = 1'b0;
                iss_vk      = lsb_cdb_result;
            end
        end
    end

    // Entry state. The dispatched entry is busy and the allocated entry is
    // not, so dispatch and issue never target the same index in one cycle.
    always_ff @(posedge clk) begin
        if (rst || rob_clear) begin
            busy    <= '0;
            qj_busy <= '0;
            qk_busy <= '0;
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                rob_id[i]     <= '0;
                op[i]         <= '0;
                instr_type[i] <= '0;
                op_other[i]   <= 1'b0;
                vj[i]         <= '0;
                vk[i]         <= '0;
                qj[i]         <= '0;
                qk[i]         <= '0;
            end
        end else if (rdy) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                if (busy[i]) begin
                    if (qj_busy[i]) begin
                        if (alu_cdb_ready && alu_cdb_rob_id == qj[i]) begin
                            vj[i]      <= alu_cdb_result;
                            qj_busy[i] <= 1'b0;
                        end else if (lsb_cdb_ready && lsb_cdb_rob_id == qj[i]) begin
                            vj[i]      <= lsb_cdb_result;
                            qj_busy[i] <= 1'b0;
                        end
                    end
                    if (qk_busy[i]) begin
                        if (alu_cdb_ready && alu_cdb_rob_id == qk[i]) begin
                            vk[i]      <= alu_cdb_result;
                            qk_busy[i] <= 1'b0;
                        end else if (lsb_cdb_ready && lsb_cdb_rob_id == qk[i]) begin
                            vk[i]      <= lsb_cdb_result;
                            qk_busy[i] <= 1'b0;
                        end
                    end
                end
                if (sel_valid && sel_idx == RS_SIZE_WIDTH'(i)) begin
                    busy[i] <= 1'b0;
                end
                if (issue_valid && alloc_valid && alloc_idx == RS_SIZE_WIDTH'(i)) begin
                    busy[i]       <= 1'b1;
                    rob_id[i]     <= issue_rob_id;
                    op[i]         <= issue_op;
                    instr_type[i] <= issue_instr_type;
                    op_other[i]   <= issue_op_other;
                    vj[i]         <= iss_vj;
                    vk[i]         <= iss_vk;
                    qj_busy[i]    <= iss_qj_busy;
                    qk_busy[i]    <= iss_qk_busy;
                    qj[i]         <= issue_qj;
                    qk[i]         <= issue_qk;
                end
            end
        end
    end

    // Dispatch register
    always_ff @(posedge clk) begin
        if (rst || rob_clear) begin
            alu_valid      <= 1'b0;
            alu_rob_id     <= '0;
            alu_op         <= '0;
            alu_instr_type <= '0;
            alu_op_other   <= 1'b0;
            alu_v1         <= '0;
            alu_v2         <= '0;
        end else if (rdy) begin
            alu_valid <= sel_valid;
            if (sel_valid) begin
                alu_rob_id     <= rob_id[sel_idx];
                alu_op         <= op[sel_idx];
                alu_instr_type <= instr_type[sel_idx];
                alu_op_other   <= op_other[sel_idx];
                alu_v1         <= vj[sel_idx];
                alu_v2         <= vk[sel_idx];
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs -- scoreboard bench for alu_rs. Expected dispatches are queued
// when an instruction is issued and compared when alu_valid is seen.

module tb_alu_rs;

    localparam int ROB_W = 4;

    typedef struct packed {
        logic [ROB_W-1:0] rob_id;
        logic [2:0]       op;
        logic [6:0]       itype;
        logic             other;
        logic [31:0]      v1;
        logic [31:0]      v2;
    } disp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rdy = 1'b1;
    logic             rob_clear = 1'b0;
    logic             issue_valid = 1'b0;
    logic [ROB_W-1:0] issue_rob_id = '0;
    logic [2:0]       issue_op = '0;
    logic [6:0]       issue_instr_type = '0;
    logic             issue_op_other = 1'b0;
    logic [31:0]      issue_vj = '0;
    logic [31:0]      issue_vk = '0;
    logic             issue_qj_busy = 1'b0;
    logic             issue_qk_busy = 1'b0;
    logic [ROB_W-1:0] issue_qj = '0;
    logic [ROB_W-1:0] issue_qk = '0;
    logic             alu_cdb_ready = 1'b0;
    logic [ROB_W-1:0] alu_cdb_rob_id = '0;
    logic [31:0]      alu_cdb_result = '0;
    logic             lsb_cdb_ready = 1'b0;
    logic [ROB_W-1:0] lsb_cdb_rob_id = '0;
    logic [31:0]      lsb_cdb_result = '0;

    logic             full;
    logic             alu_valid;
    logic [ROB_W-1:0] alu_rob_id;
    logic [2:0]       alu_op;
    logic [6:0]       alu_instr_type;
    logic             alu_op_other;
    logic [31:0]      alu_v1;
    logic [31:0]      alu_v2;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    disp_t       exp_q[$];

    alu_rs #(.RS_SIZE_WIDTH(3), .ROB_W(ROB_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear),
        .issue_valid(issue_valid), .issue_rob_id(issue_rob_id),
        .issue_op(issue_op), .issue_instr_type(issue_instr_type),
        .issue_op_other(issue_op_other), .issue_vj(issue_vj), .issue_vk(issue_vk),
        .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
        .issue_qj(issue_qj), .issue_qk(issue_qk),
        .alu_cdb_ready(alu_cdb_ready), .alu_cdb_rob_id(alu_cdb_rob_id),
        .alu_cdb_result(alu_cdb_result),
        .lsb_cdb_ready(lsb_cdb_ready), .lsb_cdb_rob_id(lsb_cdb_rob_id),
        .lsb_cdb_result(lsb_cdb_result),
        .full(full), .alu_valid(alu_valid), .alu_rob_id(alu_rob_id),
        .alu_op(alu_op), .alu_instr_type(alu_instr_type),
        .alu_op_other(alu_op_other), .alu_v1(alu_v1), .alu_v2(alu_v2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every dispatch seen must match the head of the queue
    always @(negedge clk) begin
        if (alu_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_dispatch", {60'd0, alu_rob_id}, 64'hFFFF);
            end else begin
                disp_t e;
                e = exp_q.pop_front();
                check("disp_rob", {60'd0, alu_rob_id}, {60'd0, e.rob_id});
                check("disp_ctl", {53'd0, alu_op, alu_instr_type, alu_op_other},
                      {53'd0, e.op, e.itype, e.other});
                check("disp_v1", {32'd0, alu_v1}, {32'd0, e.v1});
                check("disp_v2", {32'd0, alu_v2}, {32'd0, e.v2});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic [ROB_W-1:0] id, input logic [2:0] op,
                             input logic [6:0] it, input logic oth,
                             input logic [31:0] vj, input logic [31:0] vk,
                             input logic jb, input logic [ROB_W-1:0] qj,
                             input logic kb, input logic [ROB_W-1:0] qk);
        issue_valid      = 1'b1;
        issue_rob_id     = id;
        issue_op         = op;
        issue_instr_type = it;
        issue_op_other   = oth;
        issue_vj         = vj;
        issue_vk         = vk;
        issue_qj_busy    = jb;
        issue_qj         = qj;
        issue_qk_busy    = kb;
        issue_qk         = qk;
    endtask

    task automatic push(input logic [ROB_W-1:0] id, input logic [2:0] op,
                        input logic [6:0] it, input logic oth,
                        input logic [31:0] v1, input logic [31:0] v2);
        disp_t e;
        e.rob_id = id; e.op = op; e.itype = it; e.other = oth; e.v1 = v1; e.v2 = v2;
        exp_q.push_back(e);
    endtask

    task automatic clear_inputs();
        issue_valid   = 1'b0;
        issue_qj_busy = 1'b0;
        issue_qk_busy = 1'b0;
        alu_cdb_ready = 1'b0;
        lsb_cdb_ready = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_full"}, {63'd0, full}, 64'd0);
        check({tag, "_valid"}, {63'd0, alu_valid}, 64'd0);
        check({tag, "_outs"}, {alu_rob_id, alu_op, alu_instr_type, alu_op_other, alu_v1[20:0]}, 64'd0);
        check({tag, "_v"}, {alu_v1, alu_v2}, 64'd0);
    endtask

    initial begin
        // Reset
        tick(); tick();
        rst = 1'b0;
        check_zero_outputs("reset");

        // Ready issue: dispatched one cycle after issue edge
        set_issue(4'd3, 3'b000, 7'b0110011, 1'b0, 32'd5, 32'd7, 1'b0, '0, 1'b0, '0);
        push(4'd3, 3'b000, 7'b0110011, 1'b0, 32'd5, 32'd7);
        tick();
        clear_inputs();
        check("ready_n0_valid", {63'd0, alu_valid}, 64'd0);
        tick();
        check("ready_n1_valid", {63'd0, alu_valid}, 64'd1);
        tick();
        check("ready_n2_valid", {63'd0, alu_valid}, 64'd0);

        // Wakeup through LSB bus
        set_issue(4'd4, 3'b001, 7'b1100011, 1'b0, 32'hDEAD, 32'd1, 1'b1, 4'd2, 1'b0, '0);
        push(4'd4, 3'b001, 7'b1100011, 1'b0, 32'h10, 32'd1);
        tick();
        clear_inputs();
        tick(); tick();
        check("wake_wait_valid", {63'd0, alu_valid}, 64'd0);
        lsb_cdb_ready = 1'b1; lsb_cdb_rob_id = 4'd2; lsb_cdb_result = 32'h10;
        tick();
        clear_inputs();
        check("wake_edge_valid", {63'd0, alu_valid}, 64'd0);
        tick();
        check("wake_disp_valid", {63'd0, alu_valid}, 64'd1);
        tick();

        // Issue-time bypass from ALU bus on k operand, with sub flag
        set_issue(4'd5, 3'b000, 7'b0110011, 1'b1, 32'd3, 32'hBEEF, 1'b0, '0, 1'b1, 4'd6);
        alu_cdb_ready = 1'b1; alu_cdb_rob_id = 4'd6; alu_cdb_result = 32'd9;
        push(4'd5, 3'b000, 7'b0110011, 1'b1, 32'd3, 32'd9);
        tick();
        clear_inputs();
        tick();
        check("bypass_valid", {63'd0, alu_valid}, 64'd1);
        tick();

        // rdy low holds a ready entry
        set_issue(4'd7, 3'b111, 7'b0010011, 1'b0, 32'h77, 32'h88, 1'b0, '0, 1'b0, '0);
        push(4'd7, 3'b111, 7'b0010011, 1'b0, 32'h77, 32'h88);
        tick();
        clear_inputs();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rdy_low_valid", {63'd0, alu_valid}, 64'd0);
        end
        rdy = 1'b1;
        tick();
        check("rdy_back_valid", {63'd0, alu_valid}, 64'd1);
        tick();

        // Fill all eight entries blocked on tag 1
        for (int i = 0; i < 8; i++) begin
            check("fill_not_full", {63'd0, full}, 64'd0);
            set_issue(4'(8 + i), 3'(i), 7'b0110011, 1'b0, 32'h0, 32'(i), 1'b1, 4'd1, 1'b0, '0);
            push(4'(8 + i), 3'(i), 7'b0110011, 1'b0, 32'hAB, 32'(i));
            tick();
        end
        clear_inputs();
        check("fill_full", {63'd0, full}, 64'd1);
        check("fill_no_disp", {63'd0, alu_valid}, 64'd0);
        alu_cdb_ready = 1'b1; alu_cdb_rob_id = 4'd1; alu_cdb_result = 32'hAB;
        tick();
        clear_inputs();
        check("wake_all_still_full", {63'd0, full}, 64'd1);
        tick();
        check("first_disp_frees", {63'd0, full}, 64'd0);
        for (int i = 0; i < 7; i++) tick();
        check("drain_last_valid", {63'd0, alu_valid}, 64'd1);
        tick();
        check("drain_done_valid", {63'd0, alu_valid}, 64'd0);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset with stale entries
        for (int i = 0; i < 3; i++) begin
            set_issue(4'(i), 3'b000, 7'b0110011, 1'b0, 32'h0, 32'h0, 1'b1, 4'd12, 1'b0, '0);
            tick();
        end
        clear_inputs();
        rst = 1'b1;
        set_issue(4'd13, 3'b000, 7'b0110011, 1'b0, 32'd1, 32'd1, 1'b0, '0, 1'b0, '0);
        tick();
        clear_inputs();
        rst = 1'b0;
        check_zero_outputs("stale_reset");
        alu_cdb_ready = 1'b1; alu_cdb_rob_id = 4'd12; alu_cdb_result = 32'h5;
        tick();
        clear_inputs();
        tick(); tick();

        // Flush with concurrent issue and broadcast: nothing may dispatch later
        set_issue(4'd9, 3'b010, 7'b0110011, 1'b0, 32'h11, 32'h22, 1'b0, '0, 1'b0, '0);
        push(4'd9, 3'b010, 7'b0110011, 1'b0, 32'h11, 32'h22);
        tick();
        for (int i = 0; i < 5; i++) begin
            set_issue(4'(i), 3'b000, 7'b0110011, 1'b0, 32'h0, 32'h0, 1'b1, 4'd2, 1'b0, '0);
            tick();
        end
        clear_inputs();
        rob_clear = 1'b1;
        set_issue(4'd14, 3'b000, 7'b0110011, 1'b0, 32'h1, 32'h2, 1'b0, '0, 1'b0, '0);
        lsb_cdb_ready = 1'b1; lsb_cdb_rob_id = 4'd2; lsb_cdb_result = 32'h3;
        tick();
        clear_inputs();
        rob_clear = 1'b0;
        check_zero_outputs("flush");
        alu_cdb_ready = 1'b1; alu_cdb_rob_id = 4'd2; alu_cdb_result = 32'h4;
        tick();
        clear_inputs();
        for (int i = 0; i < 4; i++) tick();
        check("flush_no_disp", {63'd0, alu_valid}, 64'd0);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
